// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 master that reads a block of 32-bit words from
// a serial flash. It sends READ (0x03) and a 24-bit address, then streams data
// bytes in. Every four bytes form one little-endian word on a valid/ready port.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle request, sampled only in IDLE
//   start_addr          flash byte address of the first byte
//   word_count          number of 32-bit words to read (0 gives an empty transfer)
//   busy, done          transfer in progress / one-cycle completion pulse
//   word_data           assembled word, lowest-address byte in [7:0]
//   word_valid          word_data holds an unconsumed word
//   word_ready          consumer accepts the word
//   spi_cs_n            flash chip select, active low
//   spi_sclk            serial clock, idle low
//   spi_mosi            master-out data (DQ0)
//   spi_miso            master-in data (DQ1)
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD_ADDR,
    S_DATA,
    S_CS_HOLD,
    S_WAIT_DRAIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] words_left;
  logic [31:0]      shift_out;
  logic [30:0]      shift_in;

  logic        tick_c;
  logic        shifting_c;
  logic        stall_c;
  logic        rise_c;
  logic        fall_c;
  logic        handshake_c;
  logic [31:0] cmd_c;
  logic [31:0] full_c;
  logic [31:0] word_c;

  // Bit-timing strobes derived from the half-period divider
  assign tick_c      = (div_cnt == DIV_MAX);
  assign shifting_c  = (state == S_CMD_ADDR) || (state == S_DATA);
  assign handshake_c = word_valid && word_ready;
  // Hold SCLK low before a new word while the output register is still full
  assign stall_c     = (state == S_DATA) && !spi_sclk && (bit_cnt == 5'd0) &&
                       word_valid && !word_ready;
  assign rise_c      = shifting_c && tick_c && !spi_sclk && !stall_c;
  assign fall_c      = shifting_c && tick_c && spi_sclk;
  assign cmd_c       = {CMD_READ, start_addr};

  // Bytes arrive MSB first in address order; swap bytes to little-endian
  assign full_c = {shift_in, spi_miso};
  assign word_c = {full_c[7:0], full_c[15:8], full_c[23:16], full_c[31:24]};

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start && (word_count != '0)) state_next = S_CS_SETUP;
      S_CS_SETUP:   if (tick_c) state_next = S_CMD_ADDR;
      S_CMD_ADDR:   if (fall_c && (bit_cnt == 5'd31)) state_next = S_DATA;
      S_DATA:       if (fall_c && (bit_cnt == 5'd31) && (words_left == '0))
                      state_next = S_CS_HOLD;
      S_CS_HOLD:    if (tick_c) state_next = S_WAIT_DRAIN;
      S_WAIT_DRAIN: if (!word_valid || word_ready) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // State register plus datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      shift_out  <= '0;
      shift_in   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (handshake_c) word_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            if (word_count != '0) begin
              busy       <= 1'b1;
              spi_cs_n   <= 1'b0;
              shift_out  <= cmd_c;
              spi_mosi   <= cmd_c[31];
              words_left <= word_count;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_CS_SETUP, S_CS_HOLD: begin
          div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
          if ((state == S_CS_HOLD) && tick_c) spi_cs_n <= 1'b1;
        end

        S_CMD_ADDR, S_DATA: begin
          if (!stall_c) div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
          if (rise_c) begin
            spi_sclk <= 1'b1;
            if (state == S_DATA) begin
              shift_in <= full_c[30:0];
              if (bit_cnt == 5'd31) begin
                word_data  <= word_c;
                word_valid <= 1'b1;
                words_left <= words_left - CNT_W'(1);
              end
            end
          end
          if (fall_c) begin
            spi_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + 5'd1;
            if ((state == S_CMD_ADDR) && (bit_cnt != 5'd31)) begin
              spi_mosi  <= shift_out[30];
              shift_out <= shift_out << 1;
            end else begin
              spi_mosi <= 1'b0;
            end
          end
        end

        S_WAIT_DRAIN: begin
          if (!word_valid || word_ready) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (CLK_DIV 2, 1, 4) share stimulus
// and each talks to its own serial-flash model. Expected words go into a
// scoreboard queue; a monitor compares every accepted word per instance.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        word_ready = 1'b1;
  logic [23:0] start_addr = '0;
  logic [15:0] word_count = '0;

  logic [2:0]  busy_v, done_v, valid_v, cs_v, sclk_v, mosi_v;
  logic [2:0]  miso_v = '0;
  logic [31:0] data_v [3];

  logic [7:0]  mem [256];
  logic [7:0]  img [16] = '{8'h37, 8'h05, 8'h00, 8'h10, 8'h93, 8'h05, 8'ha0, 8'h0a,
                            8'h23, 8'h22, 8'hb5, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  int rd [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int fr [3] = '{0, 0, 0};
  int total_rises [3] = '{0, 0, 0};
  int cs_falls [3] = '{0, 0, 0};
  int last_edges [3] = '{0, 0, 0};
  logic [31:0] cmd [3];
  logic [31:0] last_cmd [3];
  logic [2:0]  sclk_prev = '0;
  logic [2:0]  cs_prev = '1;
  logic [31:0] exp_cmd = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    spi_flash_reader #(.CLK_DIV(DIV), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .word_count(word_count), .busy(busy_v[g]), .done(done_v[g]),
      .word_data(data_v[g]), .word_valid(valid_v[g]), .word_ready(word_ready),
      .spi_cs_n(cs_v[g]), .spi_sclk(sclk_v[g]), .spi_mosi(mosi_v[g]),
      .spi_miso(miso_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Flash model: counts SCLK rises inside CS, captures cmd/addr, drives data after falls
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sclk_v[i] && !sclk_prev[i]) total_rises[i]++;
      if (cs_v[i]) begin
        if (!cs_prev[i]) begin
          last_edges[i] = fr[i];
          last_cmd[i]   = cmd[i];
        end
        fr[i] = 0;
      end else begin
        if (cs_prev[i]) cs_falls[i]++;
        if (sclk_v[i] && !sclk_prev[i]) begin
          if (fr[i] < 32) cmd[i] = {cmd[i][30:0], mosi_v[i]};
          fr[i]++;
        end
        if (!sclk_v[i] && sclk_prev[i] && fr[i] >= 32) begin
          int k;
          logic [7:0] idx;
          logic [7:0] b;
          k   = fr[i] - 32;
          idx = 8'(cmd[i][7:0] + 8'(k / 8));
          b   = mem[idx];
          miso_v[i] = b[3'(7 - (k % 8))];
        end
      end
    end
    sclk_prev = sclk_v;
    cs_prev   = cs_v;
  end

  // Monitor: scoreboard compare on every handshake, track done pulses
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && valid_v[i] && word_ready) begin
        if (rd[i] < exp_q.size()) begin
          chk($sformatf("word_i%0d_n%0d", i, rd[i]), data_v[i], exp_q[rd[i]]);
        end else begin
          checks++;
          errors++;
          $display("FAIL extra_word_i%0d actual=0x%08h expected=none", i, data_v[i]);
        end
        rd[i]++;
      end
      if (done_v[i]) begin
        done_cnt[i]++;
        chk($sformatf("cs_high_at_done_i%0d", i), 32'(cs_v[i]), 32'h1);
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    for (int i = 0; i < 3; i++) rd[i] = 0;
  endtask

  task automatic run(input logic [23:0] a, input int n, input int edges,
                     input bit hold, input bit poke);
    int  d0 [3];
    int  r0 [3];
    int  hc;
    bit  ok;
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    exp_cmd    = {8'h03, a};
    word_ready = !hold;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy_v), 32'h7);
    hc = 0;
    ok = 1'b0;
    r0 = total_rises;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      ok = 1'b1;
      for (int i = 0; i < 3; i++) if (done_cnt[i] == d0[i]) ok = 1'b0;
      if (ok) break;
      if (poke && cyc == 30) begin
        start = 1'b1; start_addr = 24'h8; word_count = 16'd1;
      end
      if (poke && cyc == 31) begin
        start = 1'b0; start_addr = a; word_count = 16'(n);
      end
      if (hold && !word_ready) begin
        if (&valid_v) hc++;
        if (hc == 25) begin
          r0 = total_rises;
          chk("stall_sclk_low", 32'(sclk_v), 32'h0);
          chk("stall_cs_low", 32'(cs_v), 32'h0);
        end
        if (hc == 50) begin
          for (int i = 0; i < 3; i++)
            chk($sformatf("stall_frozen_i%0d", i), 32'(total_rises[i]), 32'(r0[i]));
          word_ready = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=not_done expected=done");
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_once_i%0d", i), 32'(done_cnt[i] - d0[i]), 32'h1);
      chk($sformatf("word_total_i%0d", i), 32'(rd[i]), 32'(exp_q.size()));
      chk($sformatf("sclk_edges_i%0d", i), 32'(last_edges[i]), 32'(edges));
      chk($sformatf("mosi_cmd_i%0d", i), last_cmd[i], exp_cmd);
    end
    chk("idle_cs", 32'(cs_v), 32'h7);
    chk("idle_busy", 32'(busy_v), 32'h0);
    clear_sb();
    word_ready = 1'b1;
  endtask

  initial begin
    int r0 [3];
    int f0 [3];
    int d0 [3];
    bit hit;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = img[i];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_cs_i%0d", i), 32'(cs_v[i]), 32'h1);
      chk($sformatf("rst_sclk_i%0d", i), 32'(sclk_v[i]), 32'h0);
      chk($sformatf("rst_mosi_i%0d", i), 32'(mosi_v[i]), 32'h0);
      chk($sformatf("rst_busy_i%0d", i), 32'(busy_v[i]), 32'h0);
      chk($sformatf("rst_done_i%0d", i), 32'(done_v[i]), 32'h0);
      chk($sformatf("rst_valid_i%0d", i), 32'(valid_v[i]), 32'h0);
      chk($sformatf("rst_data_i%0d", i), data_v[i], 32'h0);
    end
    rst = 1'b0;

    // Aligned four-word read
    exp_q.push_back(32'h10000537);
    exp_q.push_back(32'h0aa00593);
    exp_q.push_back(32'h00b52223);
    exp_q.push_back(32'h0000006f);
    run(24'h000000, 4, 160, 1'b0, 1'b0);

    // Unaligned single word
    exp_q.push_back(32'h05931000);
    run(24'h000002, 1, 64, 1'b0, 1'b0);

    // Backpressure after the first word
    exp_q.push_back(32'h10000537);
    exp_q.push_back(32'h0aa00593);
    exp_q.push_back(32'h00b52223);
    exp_q.push_back(32'h0000006f);
    run(24'h000000, 4, 160, 1'b1, 1'b0);

    // Zero-length request
    r0 = total_rises;
    f0 = cs_falls;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 24'h0; word_count = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done_pulse", 32'(done_v), 32'h7);
    chk("zero_busy", 32'(busy_v), 32'h0);
    chk("zero_cs", 32'(cs_v), 32'h7);
    @(posedge clk); #1;
    chk("zero_done_clear", 32'(done_v), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("zero_edges_i%0d", i), 32'(total_rises[i] - r0[i]), 32'h0);
      chk($sformatf("zero_cs_falls_i%0d", i), 32'(cs_falls[i] - f0[i]), 32'h0);
      chk($sformatf("zero_done_once_i%0d", i), 32'(done_cnt[i] - d0[i]), 32'h1);
    end

    // Reset in the middle of the second word
    exp_q.push_back(32'h10000537);
    exp_q.push_back(32'h0aa00593);
    exp_q.push_back(32'h00b52223);
    exp_q.push_back(32'h0000006f);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 24'h0; word_count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rd[0] >= 1 && fr[0] >= 70) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL midreset_reach actual=not_reached expected=second_word");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs", 32'(cs_v), 32'h7);
    chk("midrst_sclk", 32'(sclk_v), 32'h0);
    chk("midrst_valid", 32'(valid_v), 32'h0);
    chk("midrst_busy", 32'(busy_v), 32'h0);
    rst = 1'b0;
    clear_sb();
    exp_q.push_back(32'h10000537);
    run(24'h000000, 1, 64, 1'b0, 1'b0);

    // start pulsed while busy is ignored
    exp_q.push_back(32'h10000537);
    exp_q.push_back(32'h0aa00593);
    exp_q.push_back(32'h00b52223);
    exp_q.push_back(32'h0000006f);
    run(24'h000000, 4, 160, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
